// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with duty control and period ticks
//
// Purpose: NCH independent dividers sharing one sync input. Each channel produces a
// divided clock-enable waveform (divclk) and a one-cycle tick at every period start.
// Divisor and high-time are sampled only at period start, so a period in progress
// always completes with the values it started with.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   en      in   NCH    per-channel enable
//   sync    in   1      one-cycle pulse, restarts every enabled channel
//   div     in   NCH*W  per-channel divisor, channel i at [i*W +: W]
//   high    in   NCH*W  per-channel high-time, channel i at [i*W +: W]
//   divclk  out  NCH    registered divided waveform
//   tick    out  NCH    registered period-start pulse

module clk_div_multi #(
   parameter int NCH      = 4,
   parameter int W        = 17,
   parameter int DEF_DIV  = 100000,
   parameter int DEF_HIGH = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   en,
   input  logic             sync,
   input  logic [NCH*W-1:0] div,
   input  logic [NCH*W-1:0] high,
   output logic [NCH-1:0]   divclk,
   output logic [NCH-1:0]   tick
);

   // A divisor of 0 behaves as 1 so the terminal count is always reachable.
   function automatic logic [W-1:0] eff_div_f(input logic [W-1:0] d);
      return (d == '0) ? W'(1) : d;
   endfunction

   function automatic logic [W-1:0] eff_high_f(input logic [W-1:0] d, input logic [W-1:0] h);
      logic [W-1:0] ed;
      ed = eff_div_f(d);
      return (h < ed) ? h : ed;
   endfunction

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [W-1:0] cnt_q, div_q, high_q;
      logic [W-1:0] cnt_d, div_d, high_d;
      logic [W-1:0] div_in, high_in;
      logic         en_q;
      logic         restart;
      logic         dc_d, tk_d;
      logic         dc_q, tk_q;

      assign div_in  = div[g*W +: W];
      assign high_in = high[g*W +: W];

      always_comb begin
         // en_q low means this is the first enabled edge: start a fresh period.
         restart = sync || (cnt_q == eff_div_f(div_q) - W'(1)) || !en_q;
         cnt_d   = cnt_q;
         div_d   = div_q;
         high_d  = high_q;
         tk_d    = 1'b0;
         if (!en[g]) begin
            cnt_d  = '0;
            div_d  = div_in;
            high_d = high_in;
         end else if (restart) begin
            cnt_d  = '0;
            div_d  = div_in;
            high_d = high_in;
            tk_d   = 1'b1;
         end else begin
            cnt_d  = cnt_q + W'(1);
         end
         // Compare against the active values that will be in force after this edge.
         dc_d = en[g] && (cnt_d < eff_high_f(div_d, high_d));
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= W'(DEF_DIV);
            high_q <= W'(DEF_HIGH);
            en_q   <= 1'b0;
            dc_q   <= 1'b0;
            tk_q   <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            high_q <= high_d;
            en_q   <= en[g];
            dc_q   <= dc_d;
            tk_q   <= tk_d;
         end
      end

      assign divclk[g] = dc_q;
      assign tick[g]   = tk_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi
module tb_clk_div_multi;
   localparam int NCH = 4;
   localparam int W   = 17;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [NCH-1:0]   en    = '0;
   logic             sync  = 1'b0;
   logic [NCH*W-1:0] div   = '0;
   logic [NCH*W-1:0] high  = '0;
   logic [NCH-1:0]   divclk;
   logic [NCH-1:0]   tick;

   clk_div_multi #(.NCH(NCH), .W(W), .DEF_DIV(100000), .DEF_HIGH(50000)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
      .div(div), .high(high), .divclk(divclk), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] dc;
      logic [NCH-1:0] tk;
   } exp_t;

   exp_t sb[$];
   int   m_cnt [NCH];
   int   m_div [NCH];
   int   m_high[NCH];
   bit   m_enq [NCH];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int i, input int d, input int h);
      div[i*W +: W]  = W'(d);
      high[i*W +: W] = W'(h);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_div[i] = 100000; m_high[i] = 50000; m_enq[i] = 0;
      end
   endtask

   // Reference behaviour for one clock edge given the inputs currently driven.
   task automatic model_push();
      exp_t e;
      int   d_in, h_in, ed, eh;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         d_in = int'(div[i*W +: W]);
         h_in = int'(high[i*W +: W]);
         if (!en[i]) begin
            m_cnt[i] = 0; m_div[i] = d_in; m_high[i] = h_in; m_enq[i] = 0;
         end else begin
            ed = (m_div[i] == 0) ? 1 : m_div[i];
            if (sync || m_cnt[i] == ed - 1 || !m_enq[i]) begin
               m_cnt[i] = 0; m_div[i] = d_in; m_high[i] = h_in; e.tk[i] = 1'b1;
            end else begin
               m_cnt[i]++;
            end
            ed = (m_div[i] == 0) ? 1 : m_div[i];
            eh = (m_high[i] < ed) ? m_high[i] : ed;
            e.dc[i] = (m_cnt[i] < eh);
            m_enq[i] = 1;
         end
      end
      sb.push_back(e);
   endtask

   task automatic step(input string tag);
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " divclk"}, 32'(divclk), 32'(e.dc));
         check({tag, " tick"}, 32'(tick), 32'(e.tk));
      end
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] pat;
      int         tcount;

      // Reset state
      model_reset();
      #1;
      check("reset divclk", 32'(divclk), 0);
      check("reset tick", 32'(tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: div=4 high=2 on all channels, then asynchronous reset mid-run
      for (int i = 0; i < NCH; i++) set_ch(i, 4, 2);
      en = '1;
      for (int k = 0; k < 6; k++) step("t1 run");
      while (m_cnt[0] != 0) step("t1 align");
      check("t1 pre-reset divclk0", 32'(divclk[0]), 1);
      rst_n = 1'b0;
      #1;
      check("t1 async divclk", 32'(divclk), 0);
      check("t1 async tick", 32'(tick), 0);
      model_reset();
      @(posedge clk);
      #1;
      check("t1 held divclk", 32'(divclk), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pat = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         step("t1 after");
         check("t1 pattern", 32'(divclk[0]), 32'(pat[k]));
      end
      for (int k = 0; k < 8; k++) step("t1 after");

      // Test 2: boundary divisors/high-times
      en = '0;
      step("t2 dis");
      set_ch(0, 5, 1); set_ch(1, 3, 3); set_ch(2, 0, 1); set_ch(3, 6, 0);
      en = '1;
      for (int k = 0; k < 30; k++) step("t2");

      // Test 3: mid-period change only takes effect at next period
      en = '0;
      step("t3 dis");
      set_ch(0, 10, 5);
      en = 4'b0001;
      step("t3");
      while (m_cnt[0] != 2) step("t3");
      set_ch(0, 4, 1);
      for (int k = 0; k < 20; k++) step("t3 new");

      // Test 4: sync aligns out-of-phase channels
      en = '0;
      step("t4 dis");
      set_ch(0, 8, 4); set_ch(1, 12, 6);
      en = 4'b0001;
      for (int k = 0; k < 3; k++) step("t4");
      en = 4'b0011;
      for (int k = 0; k < 2; k++) step("t4");
      sync = 1'b1;
      step("t4 sync");
      sync = 1'b0;
      check("t4 sync ticks", 32'(tick[1:0]), 3);
      for (int k = 1; k <= 24; k++) step("t4 run");
      check("t4 realign ticks", 32'(tick[1:0]), 3);

      // Test 5: sync on terminal count gives a single restart
      en = '0;
      step("t5 dis");
      set_ch(0, 4, 2);
      en = 4'b0001;
      step("t5");
      while (m_cnt[0] != 3) step("t5");
      sync = 1'b1;
      tcount = 0;
      step("t5 sync");
      sync = 1'b0;
      tcount += int'(tick[0]);
      for (int k = 0; k < 3; k++) begin
         step("t5 run");
         tcount += int'(tick[0]);
      end
      check("t5 tick count", 32'(tcount), 1);
      step("t5 next");
      check("t5 next tick", 32'(tick[0]), 1);

      // Test 6: enable toggle on ch1
      en = '0;
      step("t6 dis");
      set_ch(1, 3, 2);
      en = 4'b0010;
      for (int k = 0; k < 5; k++) step("t6 on");
      en = 4'b0000;
      for (int k = 0; k < 3; k++) step("t6 off");
      check("t6 off divclk1", 32'(divclk[1]), 0);
      check("t6 off tick1", 32'(tick[1]), 0);
      en = 4'b0010;
      step("t6 reen");
      check("t6 reen divclk1", 32'(divclk[1]), 1);
      check("t6 reen tick1", 32'(tick[1]), 1);
      for (int k = 0; k < 6; k++) step("t6 run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
